ahb_timer_scheduler: RTL

//  AHB-Lite master that shares the single AHB-Lite timer slave among N_REQ requesters.
//  It grants one timeout request at a time in round-robin order and programs the timer.
//  It waits for the timer Interrupt, then stops the timer and returns a one-cycle done

---
 rtl/ahb_timer_pkg.sv | 36 +++
 rtl/ahb_timer_scheduler_if.sv | 27 ++
 rtl/ahb_timer_scheduler_rr_arbiter.sv | 32 +++
 rtl/ahb_timer_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_timer_pkg.sv
// Shared definitions for the AHB-Lite timer scheduler: slave register map,
// HTRANS encodings, default timer width and the scheduler state/outcome types.
package ahb_timer_pkg;

    localparam int         TIMER_TW         = 30;
    localparam logic [31:0] TIMER_CTRL_ADDR  = 32'h0;
    localparam logic [31:0] TIMER_COUNT_ADDR = 32'h4;
    localparam logic [1:0] HTRANS_IDLE      = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WR_CNT,
        ST_WR_CTRL,
        ST_WR_STOP,
        ST_WAIT,
        ST_RUN,
        ST_FIN
    } sched_state_t;

    // Which write the shared WAIT state is completing.
    typedef enum logic [1:0] {
        WR_KIND_CNT,
        WR_KIND_CTRL,
        WR_KIND_STOP
    } wr_kind_t;

    // What FIN reports to the owner.
    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_DONE,
        OUT_ERR
    } outcome_t;

endpackage

// File: rtl/ahb_timer_scheduler_if.sv
// Bus between the scheduler (master) and the AHB-Lite timer slave.
//   HSEL/WORK/HWRITE/HTRANS/HADDR/HWDATA : write strobe, master -> slave
//   HREADY/HRESP                         : completion / error, slave -> master
//   Interrupt                            : sticky timer expiry, slave -> master
interface ahb_timer_scheduler_if #(
    parameter int TW = 30
);
    logic          HSEL;
    logic          WORK;
    logic [TW-1:0] HADDR;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HRESP;
    logic          Interrupt;

    modport master (
        output HSEL, WORK, HADDR, HWRITE, HTRANS, HWDATA,
        input  HREADY, HRESP, Interrupt
    );

    modport slave (
        input  HSEL, WORK, HADDR, HWRITE, HTRANS, HWDATA,
        output HREADY, HRESP, Interrupt
    );
endinterface

// File: rtl/ahb_timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr_i and wraps;
// the first active request wins. The caller owns and advances the pointer.
//   req_i : request vector        ptr_i : search start index (< N_REQ)
//   gnt_o : one-hot grant         idx_o : grant index   any_o : some request active
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [2:0]       idx_o,
    output logic             any_o
);
    logic [N_REQ-1:0] rot;

    always_comb begin
        // Rotate so bit 0 is the requester at ptr_i.
        rot   = N_REQ'({req_i, req_i} >> ptr_i);
        any_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!any_o && rot[off]) begin
                any_o = 1'b1;
                idx_o = 3'((int'(ptr_i) + off) % N_REQ);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            gnt_o[i] = any_o && (idx_o == 3'(i));
        end
    end
endmodule

// File: rtl/ahb_timer_scheduler.sv
// Shares one AHB-Lite timer slave among N_REQ requesters. One timeout at a
// time is granted round-robin, the timer is programmed (COUNT then CTRL),
// the scheduler waits for Interrupt, stops the timer and pulses done/err
// to the owner.
//   HCLK, HRESET      : clock, async active-high reset
//   req, dur          : per-requester level request and timeout in cycles
//   done, err         : one-cycle pulses to the owner
//   busy, grant_id    : ownership status
//   bus               : master side of the timer slave bus
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no owner, waiting for any req
// ST_ARB     | pick owner, latch dur|1 and id, advance pointer
// ST_WR_CNT  | strobe COUNT write (clear count, load target)
// ST_WR_CTRL | strobe CTRL write (enable, target)
// ST_WR_STOP | strobe CTRL write of 0 (disable, clear Interrupt)
// ST_WAIT    | wait for HREADY of the last strobe, bounded by MAX_WAIT
// ST_RUN     | timer running, watch Interrupt and owner cancel
// ST_FIN     | pulse done/err (or nothing on cancel), then idle
module ahb_timer_scheduler
    import ahb_timer_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TW       = TIMER_TW,
    parameter int MAX_WAIT = 15
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*TW-1:0] dur,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ-1:0]    err,
    output logic                busy,
    output logic [2:0]          grant_id,
    ahb_timer_scheduler_if.master bus
);

    sched_state_t  state_q, state_d;
    wr_kind_t      wr_kind_q, wr_kind_d;
    outcome_t      outcome_q, outcome_d;
    logic [2:0]    id_q, id_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [TW-1:0] deff_q, deff_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          cancel_q, cancel_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [2:0]       arb_idx;
    logic             arb_any;
    logic [TW-1:0]    dur_sel;
    logic             owner_req;
    logic             cancel_now;
    logic             bus_fail;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        dur_sel   = '0;
        owner_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) dur_sel = dur[i*TW +: TW];
            if (id_q == 3'(i)) owner_req = req[i];
        end
    end

    // A cancel seen during the start writes is remembered so the write in
    // flight completes before the timer is stopped.
    assign cancel_now = cancel_q | ~owner_req;
    assign bus_fail   = bus.HRESP | (~bus.HREADY & (wait_cnt_q == 4'd0));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wr_kind_q  <= WR_KIND_CNT;
            outcome_q  <= OUT_NONE;
            id_q       <= '0;
            ptr_q      <= '0;
            deff_q     <= '0;
            wait_cnt_q <= '0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_kind_q  <= wr_kind_d;
            outcome_q  <= outcome_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            deff_q     <= deff_d;
            wait_cnt_q <= wait_cnt_d;
            cancel_q   <= cancel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_kind_d  = wr_kind_q;
        outcome_d  = outcome_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        deff_d     = deff_q;
        wait_cnt_d = wait_cnt_q;
        cancel_d   = cancel_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (!arb_any) begin
                    state_d = ST_IDLE;
                end else begin
                    id_d     = arb_idx;
                    ptr_d    = (arb_idx == 3'(N_REQ-1)) ? 3'd0 : arb_idx + 3'd1;
                    cancel_d = 1'b0;
                    if (dur_sel == '0) begin
                        outcome_d = OUT_ERR;
                        state_d   = ST_FIN;
                    end else begin
                        // bit0 is also the enable bit of the CTRL write
                        deff_d    = dur_sel | TW'(1);
                        outcome_d = OUT_NONE;
                        state_d   = ST_WR_CNT;
                    end
                end
            end
            ST_WR_CNT, ST_WR_CTRL: begin
                wr_kind_d  = (state_q == ST_WR_CNT) ? WR_KIND_CNT : WR_KIND_CTRL;
                wait_cnt_d = 4'(MAX_WAIT);
                cancel_d   = cancel_now;
                state_d    = ST_WAIT;
            end
            ST_WR_STOP: begin
                wr_kind_d  = WR_KIND_STOP;
                wait_cnt_d = 4'(MAX_WAIT);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_kind_q != WR_KIND_STOP) cancel_d = cancel_now;
                if (bus_fail) begin
                    outcome_d = OUT_ERR;
                    // A failing stop write must not loop back into another stop.
                    state_d   = (wr_kind_q == WR_KIND_STOP) ? ST_FIN : ST_WR_STOP;
                end else if (bus.HREADY) begin
                    case (wr_kind_q)
                        WR_KIND_CNT:  state_d = cancel_now ? ST_WR_STOP : ST_WR_CTRL;
                        WR_KIND_CTRL: state_d = cancel_now ? ST_WR_STOP : ST_RUN;
                        default:      state_d = ST_FIN;
                    endcase
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (bus.Interrupt) begin
                    outcome_d = OUT_DONE;
                    state_d   = ST_WR_STOP;
                end else if (!owner_req) begin
                    outcome_d = OUT_NONE;
                    state_d   = ST_WR_STOP;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.HSEL   = 1'b0;
        bus.WORK   = 1'b0;
        bus.HWRITE = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HADDR  = '0;
        bus.HWDATA = '0;
        if (state_q == ST_WR_CNT || state_q == ST_WR_CTRL || state_q == ST_WR_STOP) begin
            bus.HSEL   = 1'b1;
            bus.WORK   = 1'b1;
            bus.HWRITE = 1'b1;
            bus.HTRANS = HTRANS_NONSEQ;
            bus.HADDR  = (state_q == ST_WR_CNT) ? TW'(TIMER_COUNT_ADDR) : TW'(TIMER_CTRL_ADDR);
            bus.HWDATA = (state_q == ST_WR_STOP) ? 32'd0 : 32'(deff_q);
        end
    end

    always_comb begin
        done = '0;
        err  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            done[i] = (state_q == ST_FIN) && (outcome_q == OUT_DONE) && (id_q == 3'(i));
            err[i]  = (state_q == ST_FIN) && (outcome_q == OUT_ERR)  && (id_q == 3'(i));
        end
    end

    always_comb begin
        busy = 1'b1;
        if (state_q == ST_IDLE || state_q == ST_FIN) busy = 1'b0;
        else if (state_q == ST_ARB)                  busy = arb_any;

        grant_id = id_q;
        if (state_q == ST_IDLE)     grant_id = '0;
        else if (state_q == ST_ARB) grant_id = arb_idx;
    end

endmodule
